// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch direction predictor.
// Holds the FSM state enum, the mode encodings and the saturating counter step.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Counters are at most 4 bits wide; width selects the saturation ceiling.
  function automatic logic [3:0] sat_inc_dec(input logic [3:0] ctr,
                                             input logic taken,
                                             input int unsigned width);
    logic [3:0] ctr_max;
    ctr_max = 4'((1 << width) - 1);
    if (taken) begin
      return (ctr == ctr_max) ? ctr : ctr + 4'd1;
    end
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup (ID), update (EX) and status signals between the core and the predictor.
// The core drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_if #(
  parameter int IDX_W    = 8,
  parameter int GHR_BITS = 8
);
  logic                lookup_valid;
  logic [31:0]         lookup_pc;
  logic                pred_taken;
  logic [IDX_W-1:0]    pred_idx;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_valid;
  logic [IDX_W-1:0]    upd_idx;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_taken;
  logic                upd_mispredict;
  logic                ready;
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_idx, pred_ghr,
    input  ready, stat_branches, stat_mispredicts
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_idx, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_idx, pred_ghr,
    output ready, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: one combinational read port, one write port.
// The write port is shared between the post-reset init sweep and branch updates.
module bp_pht
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 256,
  parameter int CTR_BITS = 2,
  parameter int CTR_INIT = 1,
  parameter int IDX_W    = 8
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                init_en,
  input  logic [IDX_W-1:0]    init_idx,
  input  logic                upd_en,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic                upd_taken
);

  logic [CTR_BITS-1:0] mem_q [ENTRIES];
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [CTR_BITS-1:0] wr_data;

  // No bypass: a same-cycle read of the written entry returns the old count.
  assign rd_ctr = mem_q[rd_idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = init_idx;
    wr_data = CTR_BITS'(CTR_INIT);
    if (init_en) begin
      wr_en = 1'b1;
    end else if (upd_en) begin
      wr_en   = 1'b1;
      wr_idx  = upd_idx;
      wr_data = CTR_BITS'(sat_inc_dec(4'(mem_q[upd_idx]), upd_taken, CTR_BITS));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare direction predictor with speculative global history,
// mispredict history repair, post-reset table sweep and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 256,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 8,
  parameter int MODE     = MODE_GSHARE,
  parameter int CTR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_state_e           state_q, state_d;
  logic [IDX_W-1:0]    init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_branches_q, stat_branches_d;
  logic [31:0]         stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_W-1:0]    hist_idx;
  logic [IDX_W-1:0]    lookup_idx;
  logic [CTR_BITS-1:0] rd_ctr;
  logic                pred_taken;
  logic                init_en;
  logic                upd_en;
  logic                unused_bits;

  assign hist_idx   = (MODE == MODE_GSHARE) ? IDX_W'(ghr_q) : '0;
  assign lookup_idx = bp.lookup_pc[IDX_W+1:2] ^ hist_idx;
  assign pred_taken = (state_q == RUN) && rd_ctr[CTR_BITS-1];

  assign bp.pred_taken       = pred_taken;
  assign bp.pred_idx         = lookup_idx;
  assign bp.pred_ghr         = ghr_q;
  assign bp.ready            = (state_q == RUN);
  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;

  assign unused_bits = ^{bp.lookup_pc[31:IDX_W+2], bp.lookup_pc[1:0], rd_ctr};

  bp_pht #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .CTR_INIT (CTR_INIT),
    .IDX_W    (IDX_W)
  ) u_pht (
    .clk       (clk),
    .rd_idx    (lookup_idx),
    .rd_ctr    (rd_ctr),
    .init_en   (init_en),
    .init_idx  (init_ptr_q),
    .upd_en    (upd_en),
    .upd_idx   (bp.upd_idx),
    .upd_taken (bp.upd_taken)
  );

  always_comb begin
    state_d            = state_q;
    init_ptr_d         = init_ptr_q;
    ghr_d              = ghr_q;
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    init_en            = 1'b0;
    upd_en             = 1'b0;
    case (state_q)
      INIT: begin
        init_en    = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        upd_en = bp.upd_valid;
        // A mispredict flushes ID, so its repaired history wins over the lookup shift.
        if (bp.upd_valid && bp.upd_mispredict) begin
          ghr_d = (bp.upd_ghr << 1) | GHR_BITS'(bp.upd_taken);
        end else if (bp.lookup_valid) begin
          ghr_d = (ghr_q << 1) | GHR_BITS'(pred_taken);
        end
        if (bp.upd_valid) begin
          stat_branches_d = (stat_branches_q == '1) ? stat_branches_q
                                                    : stat_branches_q + 32'd1;
          if (bp.upd_mispredict) begin
            stat_mispredicts_d = (stat_mispredicts_q == '1) ? stat_mispredicts_q
                                                            : stat_mispredicts_q + 32'd1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= INIT;
      init_ptr_q         <= '0;
      ghr_q              <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      state_q            <= state_d;
      init_ptr_q         <= init_ptr_d;
      ghr_q              <= ghr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direction predictor for the pipelined RV32 core. It replaces the fixed 256-entry, 2-bit, pc-indexed table embedded in the core top.
- Supports two modes: bimodal (pc index) and gshare (pc XOR global history). Counter width, table depth and history length are configurable.
- Holds a speculative global history register (GHR) that is restored on mispredict.
- Clears its table with a post-reset sweep, so no reset fan-out loop is needed.
- Lookup is made from ID. Update arrives from EX with the index and GHR snapshot that travelled down the pipe.

Parameters:
- ENTRIES, 256, pattern table depth; power of two, at least 4; IDX_W = log2(ENTRIES).
- CTR_BITS, 2, saturating counter width, 1..4.
- GHR_BITS, 8, global history length, 1..IDX_W.
- MODE, 1, 0 = bimodal, 1 = gshare.
- CTR_INIT, 1, counter value written by the init sweep (weakly not-taken for 2 bits).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- lookup_valid  in  1  ID holds a valid conditional branch
- lookup_pc  in  32  pc of the ID instruction
- pred_taken  out  1  predicted direction, combinational
- pred_idx  out  IDX_W  table index used; carried to EX
- pred_ghr  out  GHR_BITS  GHR value before this lookup's shift; carried to EX
- upd_valid  in  1  EX resolves a conditional branch
- upd_idx  in  IDX_W  pred_idx carried with that branch
- upd_ghr  in  GHR_BITS  pred_ghr carried with that branch
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  prediction was wrong
- ready  out  1  init sweep complete
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Reset (async, rst_n low):
  - state = INIT, init_ptr = 0, GHR = 0, ready = 0, both stat counters = 0.
  - The table contents are not reset directly.
  - Asserting reset mid-sweep restarts the sweep from 0.
- INIT state:
  - Each cycle, entry[init_ptr] <= CTR_INIT and init_ptr increments.
  - After writing entry ENTRIES-1: state = RUN and ready = 1 on the next cycle. The sweep takes exactly ENTRIES cycles after reset release.
  - While in INIT: pred_taken = 0, pred_idx and pred_ghr are still driven, lookups do not shift the GHR, updates are dropped, and stats do not count.
- Index:
  - MODE 0: idx = lookup_pc[IDX_W+1:2].
  - MODE 1: idx = lookup_pc[IDX_W+1:2] XOR the zero-extended GHR.
  - pred_taken = entry[idx][CTR_BITS-1], valid in the same cycle as the lookup.
- Speculative history (RUN): when lookup_valid and no mispredict, GHR <= {GHR[GHR_BITS-2:0], pred_taken} at posedge. With GHR_BITS = 1, GHR <= pred_taken.
- Counter update (RUN, upd_valid):
  - upd_taken: entry[upd_idx] increments, saturating at 2^CTR_BITS-1.
  - not taken: entry[upd_idx] decrements, saturating at 0.
  - The write lands at posedge. A same-cycle lookup of the same index sees the pre-update value (no bypass).
- Mispredict (upd_valid and upd_mispredict):
  - GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - This overrides any same-cycle lookup shift, because the ID instruction is being flushed.
  - upd_mispredict without upd_valid is ignored.
- Stats:
  - stat_branches increments on each RUN upd_valid.
  - stat_mispredicts increments when upd_mispredict is also set.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
- No stall input: the core holds lookup_valid low while stalled so the GHR does not double-shift.

Decomposition:
- Shared package bp_pkg holds:
  - the state enum (INIT, RUN);
  - a function sat_inc_dec(ctr, taken) parametrised by width;
  - localparams MODE_BIMODAL = 0 and MODE_GSHARE = 1.
- One natural sub-module: bp_pht, the counter table storage. It has one combinational read port and one write port, with a write-select mux between the init sweep and the update path.
- GHR, FSM and stats stay in the top module.

Test Plan:
- Release reset with ENTRIES = 256 -> ready rises exactly 256 cycles later. Any entry read afterwards gives counter 1 and pred_taken = 0. Pulse reset at cycle 100 of the sweep -> ready is delayed a full 256 cycles from the new release.
- MODE 0, pc 0x40: three taken updates to idx 0x10 -> counter goes 1, 2, 3, 3 (saturates). pred_taken = 1 after the first update. Four not-taken updates -> counter reaches 0 and stays there.
- MODE 1, GHR = 0x05, lookup pc 0x40 -> pred_idx = 0x15 and pred_ghr = 0x05. With pred_taken = 0, the GHR becomes 0x0A at the next edge.
- Same cycle: lookup valid (pred 1) and mispredict update with upd_ghr = 0x81, upd_taken = 0 -> GHR = 0x02, and the speculative shift is discarded.
- Same-index collision: lookup idx 0x20 (counter 1) while upd_valid taken on idx 0x20 -> pred_taken = 0 in that cycle and 1 in the next cycle.
- Stats: 10 updates, 3 of them mispredicts -> stat_branches = 10 and stat_mispredicts = 3. Updates during INIT are not counted. Preload a counter to 0xFFFF_FFFF -> it holds at that value.
